// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO with flush; wrapping pointers carry an extra MSB
// so that full and empty are distinguishable without a separate counter.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    logic [AW:0] wr_ptr, rd_ptr;
    T mem [DEPTH];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop) rd_ptr <= rd_ptr + ONE;
        end
    end
    // Push+pop when full writes the slot being read this cycle; the read data is sampled first.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign full  = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: fetch PC, combinational ROM lookup, fault tagging and a
// prefetch FIFO feeding decode over valid/ready; redirects flush and restart fetch.
module inst_fetch_buffer
    import rv_fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter int          ROM_WORDS = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_fault
);
    localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS) * 33'd4;
    logic [31:0] fetch_pc, offset;
    logic fault, push, pop, full;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t head, tail;
    assign offset   = fetch_pc - ROM_BASE;
    assign fault    = ({1'b0, offset} >= ROM_BYTES) || (fetch_pc[1:0] != 2'b00);
    assign rom_addr = {offset[11:2], 2'b00};
    assign tail     = '{pc: fetch_pc, inst: fault ? NOP_INST : rom_inst, fault: fault};
    assign if_valid = (count != '0) && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign push     = !redirect_valid && (!full || pop);
    assign if_pc    = if_valid ? head.pc : '0;
    assign if_inst  = if_valid ? head.inst : '0;
    assign if_fault = if_valid && head.fault;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_pc;
        else if (push) fetch_pc <= fetch_pc + 32'd4;
    end
    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .din     (tail),
        .dout    (head),
        .full    (full),
        .count   (count)
    );
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed vector table for latency/backpressure/redirect/fault
// corners, then randomized traffic against a queue-based reference model.
module tb_inst_fetch_buffer;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
    localparam int          ROM_WORDS = 512;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc, if_inst;
    logic        if_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        bit          ef;
        logic [11:0] eaddr;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] q[$];
    logic [31:0] model_pc;

    inst_fetch_buffer #(
        .DEPTH(DEPTH), .RESET_PC(RESET_PC), .ROM_BASE(ROM_BASE), .ROM_WORDS(ROM_WORDS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_fault       (if_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_of(input logic [11:0] a);
        return {~a, 8'h5A, a};
    endfunction

    always_comb rom_inst = rom_of(rom_addr);

    function automatic bit flt(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - ROM_BASE;
        return (off >= 32'(ROM_WORDS * 4)) || (pc[1:0] != 2'b00);
    endfunction

    function automatic logic [11:0] exp_addr(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - ROM_BASE;
        return {off[11:2], 2'b00};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return flt(pc) ? 32'h0000_0013 : rom_of(exp_addr(pc));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic row(input bit rdy, input bit rv, input logic [31:0] rpc, input bit ev,
                       input logic [31:0] epc, input bit ef, input logic [11:0] ea);
        vec_t v;
        v.ready = rdy; v.redir = rv; v.rpc = rpc; v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = ea;
        vecs.push_back(v);
    endtask

    // Entered at posedge+1; asserts reset between edges and releases it at a later posedge+1.
    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_fault", {31'b0, if_fault}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        q.delete();
        model_pc = RESET_PC;
    endtask

    task automatic rstep(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit mv;
        if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #2;
        mv = (q.size() != 0) && !rv;
        chk("rnd_valid", {31'b0, if_valid}, {31'b0, mv});
        chk("rnd_addr", {20'b0, rom_addr}, {20'b0, exp_addr(model_pc)});
        if (mv) begin
            chk("rnd_pc", if_pc, q[0]);
            chk("rnd_inst", if_inst, exp_inst(q[0]));
            chk("rnd_fault", {31'b0, if_fault}, {31'b0, flt(q[0])});
        end
        if (rv) begin
            q.delete();
            model_pc = rpc;
        end else begin
            if (mv && rdy) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                q.push_back(model_pc);
                model_pc += 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 4))
            0: return {20'b0, 10'($urandom_range(0, 511)), 2'b00};
            1: return 32'($urandom_range(0, 2047));
            2: return 32'h7F0 + 32'(4 * $urandom_range(0, 3));
            3: return 32'h1000 + 32'($urandom);
            default: return 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        // Release, full-rate streaming, then 10 cycles of backpressure and release.
        row(1, 0, 0, 0, 32'h00, 0, 12'h000);
        row(1, 0, 0, 1, 32'h00, 0, 12'h004);
        row(1, 0, 0, 1, 32'h04, 0, 12'h008);
        row(1, 0, 0, 1, 32'h08, 0, 12'h00C);
        row(1, 0, 0, 1, 32'h0C, 0, 12'h010);
        row(1, 0, 0, 1, 32'h10, 0, 12'h014);
        row(0, 0, 0, 1, 32'h14, 0, 12'h018);
        row(0, 0, 0, 1, 32'h14, 0, 12'h01C);
        row(0, 0, 0, 1, 32'h14, 0, 12'h020);
        for (int i = 0; i < 7; i++) row(0, 0, 0, 1, 32'h14, 0, 12'h024);
        row(1, 0, 0, 1, 32'h14, 0, 12'h024);
        row(1, 0, 0, 1, 32'h18, 0, 12'h028);
        row(1, 0, 0, 1, 32'h1C, 0, 12'h02C);
        row(1, 0, 0, 1, 32'h20, 0, 12'h030);
        row(1, 0, 0, 1, 32'h24, 0, 12'h034);
        // Redirect while full, then a misaligned target and the ROM upper edge.
        row(0, 1, 32'h40, 0, 32'h00, 0, 12'h038);
        row(1, 0, 0, 0, 32'h00, 0, 12'h040);
        row(1, 0, 0, 1, 32'h40, 0, 12'h044);
        row(1, 0, 0, 1, 32'h44, 0, 12'h048);
        row(1, 1, 32'h42, 0, 32'h00, 0, 12'h04C);
        row(1, 0, 0, 0, 32'h00, 0, 12'h040);
        row(1, 0, 0, 1, 32'h42, 1, 12'h044);
        row(1, 0, 0, 1, 32'h46, 1, 12'h048);
        row(1, 1, 32'h7FC, 0, 32'h00, 0, 12'h04C);
        row(1, 0, 0, 0, 32'h00, 0, 12'h7FC);
        row(1, 0, 0, 1, 32'h7FC, 0, 12'h800);
        row(1, 0, 0, 1, 32'h800, 1, 12'h804);

        @(posedge clk);
        #1;
        do_reset();
        foreach (vecs[i]) begin
            if_ready = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #2;
            chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].ev});
            chk($sformatf("v%0d_addr", i), {20'b0, rom_addr}, {20'b0, vecs[i].eaddr});
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_pc", i), if_pc, vecs[i].epc);
                chk($sformatf("v%0d_fault", i), {31'b0, if_fault}, {31'b0, vecs[i].ef});
                chk($sformatf("v%0d_inst", i), if_inst,
                    vecs[i].ef ? 32'h0000_0013 : rom_of(vecs[i].epc[11:0]));
            end
            @(posedge clk);
            #1;
        end

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            rstep($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand_pc());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
